// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// uart_tx_arbiter
//   Shares one UART TX FIFO write port among N_REQ byte-stream requesters.
//   Round-robin arbitration at frame granularity: once granted, a requester
//   owns the FIFO until it delivers a byte flagged last. A stall watchdog
//   releases a grant whose owner stops presenting data mid-frame. Each release
//   raises a one-cycle abort pulse and bumps a saturating abort counter.
//
// Ports
//   clk, rst              rising-edge clock, asynchronous active-low reset
//   req_valid_i[k]        requester k presents a byte
//   req_data_i            byte of requester k at [k*DATA_W +: DATA_W]
//   req_last_i[k]         that byte closes requester k's frame
//   req_ready_o[k]        byte of requester k taken this cycle (valid & ready)
//   grant_o               one-hot current owner, zero when none
//   TxData_o              byte to the TX FIFO (registered)
//   n_TxFIFO_We_o         active-low FIFO write strobe, one cycle per byte
//   p_TxFIFO_Full_i       FIFO full
//   p_TxFIFO_NearFull_i   FIFO has exactly one free slot
//   p_Abort_o             one-cycle pulse when the watchdog kills a frame
//   AbortCnt_o            aborts since reset, saturating at 255
module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 1023
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid_i,
   input  logic [N_REQ*DATA_W-1:0]   req_data_i,
   input  logic [N_REQ-1:0]          req_last_i,
   output logic [N_REQ-1:0]          req_ready_o,
   output logic [N_REQ-1:0]          grant_o,
   output logic [DATA_W-1:0]         TxData_o,
   output logic                      n_TxFIFO_We_o,
   input  logic                      p_TxFIFO_Full_i,
   input  logic                      p_TxFIFO_NearFull_i,
   output logic                      p_Abort_o,
   output logic [7:0]                AbortCnt_o
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_XFER, ST_GAP} state_t;

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    grant_q, grant_d;
   logic [PTR_W-1:0]    owner_q, owner_d;     // index form of grant_q
   logic [PTR_W-1:0]    rr_q, rr_d;           // first index searched next arbitration
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic                we_n_q, we_n_d;
   logic                abort_q, abort_d;
   logic [7:0]          abort_cnt_q, abort_cnt_d;
   logic [15:0]         wd_q, wd_d;           // cycles the owner has left valid low

   // Round-robin search: first valid index at or after rr_q, wrapping.
   logic             any_valid;
   logic [PTR_W-1:0] win_idx;
   logic [PTR_W-1:0] scan_ptr;
   logic [PTR_W-1:0] rr_after_win;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      any_valid = 1'b0;
      win_idx   = '0;
      scan_ptr  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         scan_ptr = PTR_W'((int'(rr_q) + i) % N_REQ);
         if (!any_valid && req_valid_i[scan_ptr]) begin
            any_valid = 1'b1;
            win_idx   = scan_ptr;
         end
      end
   end

   assign rr_after_win = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

   // Owner-side handshake. A write already in flight consumes the last free
   // slot, so NearFull must also block acceptance while the strobe is low.
   logic              own_valid, own_last, own_ready, accept;
   logic [DATA_W-1:0] own_data;

   assign own_valid = req_valid_i[owner_q];
   assign own_last  = req_last_i[owner_q];
   assign own_data  = req_data_i[owner_q*DATA_W +: DATA_W];
   assign own_ready = (state_q == ST_XFER) && !p_TxFIFO_Full_i
                      && !(p_TxFIFO_NearFull_i && !we_n_q);
   assign accept    = own_valid && own_ready;

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      owner_d     = owner_q;
      rr_d        = rr_q;
      tx_data_d   = tx_data_q;
      we_n_d      = 1'b1;
      abort_d     = 1'b0;
      abort_cnt_d = abort_cnt_q;
      wd_d        = wd_q;

      unique case (state_q)
         ST_IDLE: begin
            wd_d = '0;
            if (any_valid) begin
               state_d          = ST_GRANT;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               owner_d          = win_idx;
               rr_d             = rr_after_win;
            end
         end
         ST_GRANT: state_d = ST_XFER;
         ST_XFER: begin
            if (accept) begin
               tx_data_d = own_data;
               we_n_d    = 1'b0;
               wd_d      = '0;
               if (own_last) begin
                  state_d = ST_GAP;
                  grant_d = '0;
               end
            end else if (!own_valid) begin
               // Only a missing byte ages the watchdog; FIFO backpressure does not.
               if (wd_q + 16'd1 == 16'(TIMEOUT)) begin
                  abort_d     = 1'b1;
                  abort_cnt_d = (abort_cnt_q == 8'hFF) ? abort_cnt_q : abort_cnt_q + 8'd1;
                  grant_d     = '0;
                  wd_d        = '0;
                  state_d     = ST_GAP;
               end else begin
                  wd_d = wd_q + 16'd1;
               end
            end
         end
         ST_GAP: begin
            wd_d    = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values computed above.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         owner_q     <= '0;
         rr_q        <= '0;
         tx_data_q   <= '0;
         we_n_q      <= 1'b1;
         abort_q     <= 1'b0;
         abort_cnt_q <= '0;
         wd_q        <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         tx_data_q   <= tx_data_d;
         we_n_q      <= we_n_d;
         abort_q     <= abort_d;
         abort_cnt_q <= abort_cnt_d;
         wd_q        <= wd_d;
      end
   end

   assign req_ready_o   = own_ready ? grant_q : '0;
   assign grant_o       = grant_q;
   assign TxData_o      = tx_data_q;
   assign n_TxFIFO_We_o = we_n_q;
   assign p_Abort_o     = abort_q;
   assign AbortCnt_o    = abort_cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// tb_uart_tx_arbiter
//   Randomised frames from four requesters against a frame-level round-robin
//   model. Stimulus pushes expected bytes, grants and abort counts into queues;
//   a monitor pops and compares whenever the DUT writes, grants or aborts.
//   A small FIFO occupancy model drives Full/NearFull and flags overflow.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TMO = 8;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       dead;    // requester stops here and waits for the watchdog
      int         stall;   // cycles with valid low before this byte is shown
   } beat_t;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_last;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    grant;
   logic [DW-1:0]   tx_data;
   logic            we_n;
   logic            full;
   logic            near_full;
   logic            p_abort;
   logic [7:0]      abort_cnt;

   uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .req_valid_i         (req_valid),
      .req_data_i          (req_data),
      .req_last_i          (req_last),
      .req_ready_o         (req_ready),
      .grant_o             (grant),
      .TxData_o            (tx_data),
      .n_TxFIFO_We_o       (we_n),
      .p_TxFIFO_Full_i     (full),
      .p_TxFIFO_NearFull_i (near_full),
      .p_Abort_o           (p_abort),
      .AbortCnt_o          (abort_cnt)
   );

   always #5 clk = ~clk;

   int vec_cnt = 0;
   int err_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   beat_t      src_q[N][$];
   beat_t      mdl_q[N][$];
   logic [7:0] exp_byte_q[$];
   int         exp_grant_q[$];
   int         exp_abort_q[$];
   int         mdl_ptr    = 0;
   int         mdl_aborts = 0;
   int         fifo_depth = 16;
   int         drain_pct  = 100;
   int         fifo_cnt   = 0;

   // Frame-level reference: every requester holding a frame is contending;
   // the first one at/after the pointer sends its whole frame, pointer moves past it.
   task automatic model_batch();
      int    w;
      int    k;
      beat_t b;
      forever begin
         w = -1;
         for (int i = 0; i < N; i++) begin
            k = (mdl_ptr + i) % N;
            if (w < 0 && mdl_q[k].size() > 0) w = k;
         end
         if (w < 0) break;
         exp_grant_q.push_back(w);
         mdl_ptr = (w + 1) % N;
         forever begin
            b = mdl_q[w].pop_front();
            if (b.dead) begin
               if (mdl_aborts < 255) mdl_aborts++;
               exp_abort_q.push_back(mdl_aborts);
               break;
            end
            exp_byte_q.push_back(b.data);
            if (b.last) break;
         end
      end
   endtask

   task automatic add_frame(input int k, input int len, input bit dead,
                            input logic [7:0] base, input bit rnd);
      beat_t b;
      for (int i = 0; i < len; i++) begin
         b.data  = rnd ? 8'($urandom) : base + 8'(i);
         b.last  = !dead && (i == len - 1);
         b.dead  = 1'b0;
         b.stall = (i > 0 && rnd && $urandom_range(3) == 0) ? int'($urandom_range(3, 1)) : 0;
         src_q[k].push_back(b);
         mdl_q[k].push_back(b);
      end
      if (dead) begin
         b.data = '0; b.last = 1'b0; b.dead = 1'b1; b.stall = 0;
         src_q[k].push_back(b);
         mdl_q[k].push_back(b);
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while ((exp_byte_q.size() > 0 || exp_grant_q.size() > 0 || exp_abort_q.size() > 0
              || grant != '0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      while (fifo_cnt != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check({name, "_completes"}, 32'(n < budget), 32'd1);
   endtask

   // Requester drivers: present the head beat, pop it once accepted.
   initial begin : driver
      logic [N-1:0] acc;
      logic         ab;
      beat_t        b;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         acc = req_valid & req_ready;
         ab  = p_abort;
         @(posedge clk);
         #1;
         if (!rst) begin
            req_valid = '0;
         end else begin
            for (int k = 0; k < N; k++) begin
               if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
               if (ab && src_q[k].size() > 0 && src_q[k][0].dead) void'(src_q[k].pop_front());
               if (src_q[k].size() == 0) begin
                  req_valid[k] = 1'b0;
               end else begin
                  b = src_q[k][0];
                  if (b.dead) begin
                     req_valid[k] = 1'b0;
                  end else if (b.stall > 0) begin
                     req_valid[k] = 1'b0;
                     b.stall--;
                     src_q[k][0] = b;
                  end else begin
                     req_valid[k]          = 1'b1;
                     req_data[k*DW +: DW]  = b.data;
                     req_last[k]           = b.last;
                  end
               end
            end
         end
      end
   end

   // TX FIFO occupancy model: a write commits at the edge ending its strobe cycle.
   initial begin : fifo
      logic wr;
      logic rd;
      full      = 1'b0;
      near_full = 1'b0;
      forever begin
         @(negedge clk);
         wr = !we_n;
         rd = (fifo_cnt > 0) && ($urandom_range(99) < drain_pct);
         @(posedge clk);
         #1;
         fifo_cnt  = fifo_cnt + int'(wr) - int'(rd);
         full      = (fifo_cnt >= fifo_depth);
         near_full = (fifo_cnt == fifo_depth - 1);
      end
   end

   // Monitor: compares every write, grant and abort against the queues.
   initial begin : monitor
      logic          prev_acc;
      logic [7:0]    prev_data;
      logic [N-1:0]  prev_grant;
      logic          prev_abort;
      int            idle_run;
      int            g;
      prev_acc = 1'b0; prev_data = '0; prev_grant = '0; prev_abort = 1'b0; idle_run = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            prev_acc = 1'b0; prev_grant = '0; prev_abort = 1'b0; idle_run = 0;
         end else begin
            if (prev_acc) begin
               check("write_strobe", 32'(we_n), 32'd0);
               check("write_latency_data", 32'(tx_data), 32'(prev_data));
            end else begin
               check("no_spurious_write", 32'(we_n), 32'd1);
            end
            if (!we_n) begin
               check("fifo_overflow", 32'(fifo_cnt < fifo_depth), 32'd1);
               if (exp_byte_q.size() == 0) begin
                  vec_cnt++; err_cnt++;
                  $display("FAIL extra_write: got 0x%0h expected no write at %0t", tx_data, $time);
               end else begin
                  check("fifo_byte", 32'(tx_data), 32'(exp_byte_q.pop_front()));
               end
            end
            check("ready_while_full", 32'(|req_ready & full), 32'd0);
            check("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
            check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
            if (grant != '0 && prev_grant == '0) begin
               if (exp_grant_q.size() == 0) begin
                  vec_cnt++; err_cnt++;
                  $display("FAIL extra_grant: got 0x%0h expected none at %0t", grant, $time);
               end else begin
                  g = exp_grant_q.pop_front();
                  check("grant_order", 32'(grant), 32'd1 << g);
               end
            end
            check("abort_pulse_width", 32'(p_abort & prev_abort), 32'd0);
            if (p_abort) begin
               check("abort_after_timeout", 32'(idle_run), 32'(TMO));
               if (exp_abort_q.size() == 0) begin
                  vec_cnt++; err_cnt++;
                  $display("FAIL extra_abort: got count %0d expected no abort at %0t", abort_cnt, $time);
               end else begin
                  check("abort_count", 32'(abort_cnt), 32'(exp_abort_q.pop_front()));
               end
            end
            // Cycles the owner has shown no byte since its last accepted one.
            if (grant == '0 || |(req_valid & req_ready)) idle_run = 0;
            else if ((req_valid & grant) == '0) idle_run++;
            prev_acc  = |(req_valid & req_ready);
            for (int k = 0; k < N; k++)
               if (grant[k]) prev_data = req_data[k*DW +: DW];
            prev_grant = grant;
            prev_abort = p_abort;
         end
      end
   end

   initial begin : main
      int n;
      rst = 1'b0;
      #12;
      check("reset_grant", 32'(grant), 32'd0);
      check("reset_ready", 32'(req_ready), 32'd0);
      check("reset_txdata", 32'(tx_data), 32'd0);
      check("reset_we_n", 32'(we_n), 32'd1);
      check("reset_abort", 32'(p_abort), 32'd0);
      check("reset_abort_cnt", 32'(abort_cnt), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Round robin: grants 0,1,2,3,0 with labelled 2-byte frames.
      add_frame(0, 2, 1'b0, 8'hA0, 1'b0);
      add_frame(1, 2, 1'b0, 8'hB0, 1'b0);
      add_frame(2, 2, 1'b0, 8'hC0, 1'b0);
      add_frame(3, 2, 1'b0, 8'hD0, 1'b0);
      add_frame(0, 2, 1'b0, 8'hE0, 1'b0);
      model_batch();
      wait_done("round_robin", 500);

      // Lock: req0 shows up mid-frame of req1 and must wait.
      add_frame(1, 5, 1'b0, 8'h10, 1'b0);
      model_batch();
      n = 0;
      while (grant != 4'b0010 && n < 200) begin @(negedge clk); n++; end
      check("lock_grant_seen", 32'(n < 200), 32'd1);
      add_frame(0, 3, 1'b0, 8'h20, 1'b0);
      model_batch();
      wait_done("lock", 500);

      // Randomised traffic under varied FIFO depth and drain rate.
      for (int p = 0; p < 8; p++) begin
         fifo_depth = (p % 4 == 0) ? 16 : int'($urandom_range(4, 2));
         drain_pct  = int'($urandom_range(100, 25));
         for (int k = 0; k < N; k++)
            for (int f = int'($urandom_range(2)); f > 0; f--)
               add_frame(k, int'($urandom_range(6, 1)), 1'b0, 8'h00, 1'b1);
         model_batch();
         wait_done("random", 4000);
      end

      // Backpressure: shallow FIFO, slow drain, one long frame.
      fifo_depth = 3;
      drain_pct  = 15;
      add_frame(0, 10, 1'b0, 8'h40, 1'b0);
      model_batch();
      wait_done("backpressure", 2000);
      fifo_depth = 16;
      drain_pct  = 100;

      // Watchdog: req2 stalls after two bytes, req3 waits behind it.
      add_frame(2, 2, 1'b1, 8'h50, 1'b0);
      add_frame(3, 2, 1'b0, 8'h60, 1'b0);
      model_batch();
      wait_done("watchdog", 500);
      check("abort_cnt_after_watchdog", 32'(abort_cnt), 32'(mdl_aborts));

      // Saturation: 260 forced aborts in batches of four.
      for (int b = 0; b < 65; b++) begin
         for (int k = 0; k < N; k++) add_frame(k, 1, 1'b1, 8'h70, 1'b1);
         model_batch();
         wait_done("saturation", 1000);
      end
      check("abort_cnt_saturated", 32'(abort_cnt), 32'd255);

      // Reset mid-frame: outputs return to reset values at once.
      drain_pct = 30;
      add_frame(1, 20, 1'b0, 8'h80, 1'b0);
      model_batch();
      n = 0;
      while (!(grant != '0 && !we_n) && n < 200) begin @(negedge clk); n++; end
      check("midframe_write_seen", 32'(n < 200), 32'd1);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("midreset_we_n", 32'(we_n), 32'd1);
      check("midreset_grant", 32'(grant), 32'd0);
      check("midreset_abort_cnt", 32'(abort_cnt), 32'd0);
      check("midreset_ready", 32'(req_ready), 32'd0);
      for (int k = 0; k < N; k++) begin
         src_q[k].delete();
         mdl_q[k].delete();
      end
      exp_byte_q.delete();
      exp_grant_q.delete();
      exp_abort_q.delete();
      mdl_ptr    = 0;
      mdl_aborts = 0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      n = 0;
      while (fifo_cnt != 0 && n < 500) begin @(negedge clk); n++; end
      drain_pct = 100;

      // Pointer restarts at 0 after reset: req1 wins over req3.
      add_frame(3, 2, 1'b0, 8'h90, 1'b0);
      add_frame(1, 2, 1'b0, 8'h98, 1'b0);
      model_batch();
      wait_done("post_reset", 500);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
